matrix_cplx_streamer: RTL and testbench

Serializes a complex result matrix, presented as packed real and imaginary planes, into a stream of one complex element per cycle with a valid/ready handshake. Sits on the output side of the complex matrix multiplier: it captures a whole `res_r`/`res_i` frame in one handshake, then drains it element by element to downstream logic (FIFO, DMA, or serial link). Traversal can be row-major or column-major, selected per frame.

---
 rtl/matrix_pkg.sv | 14 +
 rtl/matrix_idx_counter.sv | 53 +++++
 rtl/matrix_cplx_streamer.sv | 99 +++++++++
 tb/tb_matrix_cplx_streamer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the complex matrix streaming blocks.
// Holds the streamer state encoding and the index-width helper.
package matrix_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Two-dimensional row/column index counter.
// Steps in row-major or column-major order and flags the final element.
module matrix_idx_counter
    import matrix_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     step,
    input  logic                     colmaj,
    output logic [idx_w(ROWS)-1:0]   row,
    output logic [idx_w(COLS)-1:0]   col,
    output logic                     at_end
);

    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);

    logic row_last;
    logic col_last;

    assign row_last = (row == RW'(ROWS - 1));
    assign col_last = (col == CW'(COLS - 1));
    assign at_end   = row_last && col_last;

    // Advance the inner index first, carrying into the outer one on wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (colmaj) begin
                if (row_last) begin
                    row <= '0;
                    col <= col_last ? '0 : col + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_cplx_streamer.sv
// Captures a complex result frame in one handshake and drains it
// one element per cycle, row-major or column-major per frame.
module matrix_cplx_streamer
    import matrix_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_colmaj,
    input  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  mat_r,
    input  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  mat_i,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      out_re,
    output logic [WIDTH-1:0]                      out_im,
    output logic [idx_w(ROWS)-1:0]                out_row,
    output logic [idx_w(COLS)-1:0]                out_col,
    output logic                                  out_last
);

    stream_state_t state;
    stream_state_t state_nx;

    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] frm_r;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] frm_i;
    logic                                 colmaj_q;

    logic [idx_w(ROWS)-1:0] row;
    logic [idx_w(COLS)-1:0] col;
    logic                   at_end;
    logic                   cap;
    logic                   fire;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == SEND);
    assign cap       = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    matrix_idx_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (cap),
        .step   (fire),
        .colmaj (colmaj_q),
        .row    (row),
        .col    (col),
        .at_end (at_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: capture moves to SEND, last handshake returns to IDLE.
    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == IDLE): if (cap) state_nx = SEND;
            (state == SEND): if (fire && at_end) state_nx = IDLE;
            default:         state_nx = IDLE;
        endcase
    end

    // Frame registers; cleared on reset so an aborted frame leaves nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_r    <= '0;
            frm_i    <= '0;
            colmaj_q <= 1'b0;
        end else if (cap) begin
            frm_r    <= mat_r;
            frm_i    <= mat_i;
            colmaj_q <= in_colmaj;
        end
    end

    // Output mux driven only by registers, so it holds during stalls.
    always_comb begin
        out_re   = frm_r[row][col];
        out_im   = frm_i[row][col];
        out_row  = row;
        out_col  = col;
        out_last = out_valid && at_end;
    end

endmodule

// File: tb/tb_matrix_cplx_streamer.sv
// Directed bench for matrix_cplx_streamer with a 2x3 frame.
// Table of expected beats plus hand-written stall/reset/back-to-back runs.
module tb_matrix_cplx_streamer;

    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int WIDTH = 16;

    typedef struct {
        int          row;
        int          col;
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } vec_t;

    logic                                 clk;
    logic                                 rst;
    logic                                 in_valid;
    logic                                 in_ready;
    logic                                 in_colmaj;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] mat_r;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] mat_i;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [WIDTH-1:0]                     out_re;
    logic [WIDTH-1:0]                     out_im;
    logic [0:0]                           out_row;
    logic [1:0]                           out_col;
    logic                                 out_last;

    int   tests;
    int   fails;
    vec_t tab [12];

    matrix_cplx_streamer #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_colmaj (in_colmaj),
        .mat_r     (mat_r),
        .mat_i     (mat_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_planes(input logic [15:0] bre, input logic [15:0] bim);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mat_r[r][c] = bre + 16'(r * 16 + c);
                mat_i[r][c] = bim + 16'(r * 16 + c);
            end
        end
    endtask

    // Drain one frame, comparing each accepted beat against the table.
    task automatic drain(input int off, input logic [15:0] dre,
                         input logic [15:0] dim, input bit rnd);
        int          beats = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [15:0] p_re = '0;
        logic [15:0] p_im = '0;
        logic [2:0]  p_idx = '0;
        logic        p_last = 1'b0;
        while (beats < 6 && cyc < 100) begin
            chk("valid_in_frame", {31'b0, out_valid}, 32'd1);
            chk("in_ready_send", {31'b0, in_ready}, 32'd0);
            if (stalled) begin
                chk("stall_re", {16'b0, out_re}, {16'b0, p_re});
                chk("stall_im", {16'b0, out_im}, {16'b0, p_im});
                chk("stall_idx", {29'b0, out_row, out_col}, {29'b0, p_idx});
                chk("stall_last", {31'b0, out_last}, {31'b0, p_last});
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
                chk("row", {31'b0, out_row}, 32'(tab[off+beats].row));
                chk("col", {30'b0, out_col}, 32'(tab[off+beats].col));
                chk("re", {16'b0, out_re}, {16'b0, tab[off+beats].re + dre});
                chk("im", {16'b0, out_im}, {16'b0, tab[off+beats].im + dim});
                chk("last", {31'b0, out_last},
                    {31'b0, tab[off+beats].last});
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
                p_re    = out_re;
                p_im    = out_im;
                p_idx   = {out_row, out_col};
                p_last  = out_last;
            end
            tick();
            cyc++;
        end
        chk("beat_count", 32'(beats), 32'd6);
        out_ready = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        tab[0]  = '{0, 0, 16'h0100, 16'h8000, 1'b0};
        tab[1]  = '{0, 1, 16'h0101, 16'h8001, 1'b0};
        tab[2]  = '{0, 2, 16'h0102, 16'h8002, 1'b0};
        tab[3]  = '{1, 0, 16'h0110, 16'h8010, 1'b0};
        tab[4]  = '{1, 1, 16'h0111, 16'h8011, 1'b0};
        tab[5]  = '{1, 2, 16'h0112, 16'h8012, 1'b1};
        tab[6]  = '{0, 0, 16'h0100, 16'h8000, 1'b0};
        tab[7]  = '{1, 0, 16'h0110, 16'h8010, 1'b0};
        tab[8]  = '{0, 1, 16'h0101, 16'h8001, 1'b0};
        tab[9]  = '{1, 1, 16'h0111, 16'h8011, 1'b0};
        tab[10] = '{0, 2, 16'h0102, 16'h8002, 1'b0};
        tab[11] = '{1, 2, 16'h0112, 16'h8012, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_colmaj = 1'b0;
        out_ready = 1'b0;
        set_planes(16'h0100, 16'h8000);
        tick();
        tick();

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_re", {16'b0, out_re}, 32'd0);
        chk("rst_out_im", {16'b0, out_im}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_idx", {29'b0, out_row, out_col}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Row-major frame, ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(0, 16'h0, 16'h0, 1'b0);
        chk("rm_end_valid", {31'b0, out_valid}, 32'd0);
        chk("rm_end_in_ready", {31'b0, in_ready}, 32'd1);

        // Column-major frame.
        in_colmaj = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_colmaj = 1'b0;
        drain(6, 16'h0, 16'h0, 1'b0);
        chk("cm_end_valid", {31'b0, out_valid}, 32'd0);

        // Random backpressure, row-major.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(0, 16'h0, 16'h0, 1'b1);
        chk("stall_end_valid", {31'b0, out_valid}, 32'd0);
        chk("stall_end_in_ready", {31'b0, in_ready}, 32'd1);

        // in_valid held with new planes during SEND; back-to-back frames.
        in_valid = 1'b1;
        tick();
        set_planes(16'h0200, 16'h9000);
        drain(0, 16'h0, 16'h0, 1'b0);
        chk("b2b_gap_valid", {31'b0, out_valid}, 32'd0);
        chk("b2b_gap_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_first_valid", {31'b0, out_valid}, 32'd1);
        drain(0, 16'h0100, 16'h1000, 1'b0);

        // Reset on the third beat aborts the frame.
        set_planes(16'h0100, 16'h8000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_beat3_col", {30'b0, out_col}, 32'd2);
        chk("abort_beat3_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready_rst", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_re", {16'b0, out_re}, 32'd0);
        chk("abort_idx", {29'b0, out_row, out_col}, 32'd0);

        set_planes(16'h0200, 16'h9000);
        in_colmaj = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_colmaj = 1'b0;
        drain(6, 16'h0100, 16'h1000, 1'b0);
        chk("fresh_end_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
